prim_present_key_prep: RTL and testbench



---
 rtl/prim_present_key_prep.sv | 160 ++++++++++++++++
 tb/tb_prim_present_key_prep.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prim_present_key_prep.sv
// PRESENT key preparation: runs NumRounds forward key-schedule updates on an
// accepted cipher key to produce the final round key needed by a decrypting
// datapath. A one-entry cache answers a repeated key in a single cycle.
module prim_present_key_prep #(
    parameter int unsigned KeyWidth  = 128,
    parameter int unsigned NumRounds = 31
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                key_valid_i,
    output logic                key_ready_o,
    input  logic [KeyWidth-1:0] key_i,
    input  logic                clear_i,
    output logic                dec_key_valid_o,
    input  logic                dec_key_ready_i,
    output logic [KeyWidth-1:0] dec_key_o,
    output logic                busy_o,
    output logic                cache_hit_o
);

    // Elaboration-time parameter legality.
    if (!(KeyWidth == 64 || KeyWidth == 80 || KeyWidth == 128)) begin : gen_bad_key_width
        $error("prim_present_key_prep: KeyWidth must be 64, 80 or 128");
    end
    if (NumRounds < 1 || NumRounds > 31) begin : gen_bad_num_rounds
        $error("prim_present_key_prep: NumRounds must be in 1..31");
    end

    localparam logic [4:0] LastRound = 5'(NumRounds);
    // Round-counter injection point: bits 66:62 for 128-bit keys, 19:15 otherwise.
    localparam int unsigned RcLsb = (KeyWidth == 128) ? 62 : 15;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // PRESENT 4-bit S-box.
    function automatic logic [3:0] sbox4(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    // One forward key-schedule step, equivalent to present_update_key{64,80,128}:
    // rotate left by 61, S-box the top nibble (top two for 128-bit keys),
    // then XOR the round counter into the key.
    function automatic logic [KeyWidth-1:0] update_key(input logic [KeyWidth-1:0] k,
                                                       input logic [4:0]          rc);
        logic [KeyWidth-1:0] r;
        r = {k[KeyWidth-62:0], k[KeyWidth-1:KeyWidth-61]};
        r[KeyWidth-1 -: 4] = sbox4(r[KeyWidth-1 -: 4]);
        if (KeyWidth == 128) begin
            r[KeyWidth-5 -: 4] = sbox4(r[KeyWidth-5 -: 4]);
        end
        r[RcLsb +: 5] = r[RcLsb +: 5] ^ rc;
        return r;
    endfunction

    state_e              state_q, state_d;
    logic [4:0]          cnt_q;
    logic                cache_valid_q;
    logic                clear_seen_q;
    logic [KeyWidth-1:0] work_q;
    logic [KeyWidth-1:0] pending_key_q;
    logic [KeyWidth-1:0] cache_key_q;
    logic [KeyWidth-1:0] cache_res_q;

    logic                accept;
    logic                hit;
    logic                miss;
    logic                last_round;
    logic                cache_write;
    logic [KeyWidth-1:0] next_work;

    assign key_ready_o = (state_q == StIdle);
    assign accept      = key_valid_i & key_ready_o;
    assign hit         = accept & cache_valid_q & (key_i == cache_key_q) & ~clear_i;
    assign miss        = accept & ~hit;
    assign last_round  = (state_q == StRun) & (cnt_q == LastRound);
    // A clear at any point of the run, including its last cycle, blocks caching.
    assign cache_write = last_round & ~clear_seen_q & ~clear_i;
    assign next_work   = update_key(work_q, cnt_q);

    // Next-state decode.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            StIdle: if (accept) state_d = hit ? StDone : StRun;
            StRun:  if (cnt_q == LastRound) state_d = StDone;
            StDone: if (dec_key_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Control state, cache bookkeeping and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q         <= StIdle;
            cnt_q           <= '0;
            cache_valid_q   <= 1'b0;
            clear_seen_q    <= 1'b0;
            dec_key_o       <= '0;
            dec_key_valid_o <= 1'b0;
            busy_o          <= 1'b0;
            cache_hit_o     <= 1'b0;
        end else begin
            state_q         <= state_d;
            dec_key_valid_o <= (state_d == StDone);
            busy_o          <= (state_d == StRun);
            cache_hit_o     <= hit;

            if (miss) begin
                cnt_q        <= 5'd1;
                clear_seen_q <= 1'b0;
            end else if (state_q == StRun) begin
                // Hold on the last round so the 5-bit counter never wraps.
                if (!last_round) cnt_q <= cnt_q + 5'd1;
                clear_seen_q <= clear_seen_q | clear_i;
            end

            if (hit) begin
                dec_key_o <= cache_res_q;
            end else if (last_round) begin
                dec_key_o <= next_work;
            end

            if (clear_i) begin
                cache_valid_q <= 1'b0;
            end else if (cache_write) begin
                cache_valid_q <= 1'b1;
            end
        end
    end

    // Key datapath and cache contents.
    always_ff @(posedge clk_i) begin
        // NOTE: no reset here; these wide registers are only read once qualified
        // by state or cache_valid_q, which are reset.
        if (miss) begin
            work_q        <= key_i;
            pending_key_q <= key_i;
        end else if (state_q == StRun) begin
            work_q <= next_work;
        end
        if (cache_write) begin
            cache_key_q <= pending_key_q;
            cache_res_q <= next_work;
        end
    end

endmodule

// File: tb/tb_prim_present_key_prep.sv
// Self-checking bench for prim_present_key_prep: directed timing tests, small
// instances pinned by hand-computed keys, and randomized traffic on the
// 128-bit/31-round instance compared every cycle against a behavioural model.
module tb_prim_present_key_prep;

    localparam int W = 128;
    localparam int N = 31;
    localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                         4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    int total = 0;
    int bad   = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main instance (128-bit, 31 rounds).
    logic           kv = 1'b0, clr = 1'b0, drdy = 1'b0;
    logic [W-1:0]   key = '0;
    logic           rdy, dvalid, busy, hit;
    logic [W-1:0]   dkey;

    prim_present_key_prep #(.KeyWidth(W), .NumRounds(N)) u_dut (
        .clk_i(clk), .rst_i(rst), .key_valid_i(kv), .key_ready_o(rdy), .key_i(key),
        .clear_i(clr), .dec_key_valid_o(dvalid), .dec_key_ready_i(drdy),
        .dec_key_o(dkey), .busy_o(busy), .cache_hit_o(hit)
    );

    // Single-round instances for each key width, driven together.
    logic           kv_s = 1'b0, drdy_s = 1'b0;
    logic [W-1:0]   key_s = '0;
    logic           r80, v80, b80, h80, r128, v128, b128, h128, r64, v64, b64, h64;
    logic [79:0]    k80;
    logic [127:0]   k128;
    logic [63:0]    k64;

    prim_present_key_prep #(.KeyWidth(80), .NumRounds(1)) u_dut80 (
        .clk_i(clk), .rst_i(rst), .key_valid_i(kv_s), .key_ready_o(r80), .key_i(key_s[79:0]),
        .clear_i(1'b0), .dec_key_valid_o(v80), .dec_key_ready_i(drdy_s),
        .dec_key_o(k80), .busy_o(b80), .cache_hit_o(h80)
    );
    prim_present_key_prep #(.KeyWidth(128), .NumRounds(1)) u_dut128 (
        .clk_i(clk), .rst_i(rst), .key_valid_i(kv_s), .key_ready_o(r128), .key_i(key_s),
        .clear_i(1'b0), .dec_key_valid_o(v128), .dec_key_ready_i(drdy_s),
        .dec_key_o(k128), .busy_o(b128), .cache_hit_o(h128)
    );
    prim_present_key_prep #(.KeyWidth(64), .NumRounds(1)) u_dut64 (
        .clk_i(clk), .rst_i(rst), .key_valid_i(kv_s), .key_ready_o(r64), .key_i(key_s[63:0]),
        .clear_i(1'b0), .dec_key_valid_o(v64), .dec_key_ready_i(drdy_s),
        .dec_key_o(k64), .busy_o(b64), .cache_hit_o(h64)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Golden forward key schedule: n updates with counters 1..n on a w-bit key.
    function automatic logic [127:0] model_final(input int w, input int n, input logic [127:0] k);
        logic [127:0] mask, x, rc;
        int pos;
        mask = (w == 128) ? {128{1'b1}} : ((128'd1 << w) - 128'd1);
        pos  = (w == 128) ? 62 : 15;
        x    = k & mask;
        for (int r = 1; r <= n; r++) begin
            x = ((x << 61) | (x >> (w - 61))) & mask;
            x[w-1 -: 4] = SBOX[x[w-1 -: 4]];
            if (w == 128) x[w-5 -: 4] = SBOX[x[w-5 -: 4]];
            rc = 128'(r);
            x  = x ^ (rc << pos);
        end
        return x;
    endfunction

    // Behavioural model of the main instance: phase 0 idle, 1 computing, 2 presenting.
    int           m_phase = 0;
    int           m_left  = 0;
    logic         m_clr_seen = 1'b0;
    logic         m_cache_v  = 1'b0;
    logic [127:0] m_cache_k = '0, m_cache_r = '0, m_pend = '0, m_res = '0, m_dec = '0;
    logic         m_hit = 1'b0;
    logic         chk_en = 1'b0;

    // Model advances on the same edge as the DUT, from the inputs it sampled.
    always @(posedge clk) begin
        if (rst) begin
            m_phase   = 0;
            m_cache_v = 1'b0;
            m_dec     = '0;
            m_hit     = 1'b0;
        end else begin
            m_hit = 1'b0;
            case (m_phase)
                0: if (kv) begin
                    if (m_cache_v && key == m_cache_k && !clr) begin
                        m_dec   = m_cache_r;
                        m_hit   = 1'b1;
                        m_phase = 2;
                    end else begin
                        m_pend     = key;
                        m_res      = model_final(W, N, key);
                        m_left     = N;
                        m_clr_seen = 1'b0;
                        m_phase    = 1;
                    end
                end
                1: begin
                    if (clr) m_clr_seen = 1'b1;
                    m_left--;
                    if (m_left == 0) begin
                        m_dec   = m_res;
                        m_phase = 2;
                        if (!m_clr_seen) begin
                            m_cache_k = m_pend;
                            m_cache_r = m_res;
                            m_cache_v = 1'b1;
                        end
                    end
                end
                default: if (drdy) m_phase = 0;
            endcase
            if (clr) m_cache_v = 1'b0;
        end
    end

    // Compare every output of the main instance against the model each cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_ready", rdy,    m_phase == 0);
            check("cyc_busy",  busy,   m_phase == 1);
            check("cyc_valid", dvalid, m_phase == 2);
            check("cyc_hit",   hit,    m_hit);
            check("cyc_key",   dkey,   m_dec);
        end
    end

    // Submit one key, optionally pulsing clear or reset at a given cycle offset
    // (0 = accept cycle), and measure latency/busy cycles. lat = -1 after reset.
    task automatic run_key(input logic [127:0] k, input int clr_at, input int rst_at,
                           output int lat, output int busy_n, output logic hit_seen);
        int n = 0;
        while (!rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        kv  = 1'b1;
        key = k;
        clr = (clr_at == 0);
        @(negedge clk);
        kv       = 1'b0;
        lat      = 1;
        busy_n   = 0;
        hit_seen = 1'b0;
        while (lat < 200) begin
            if (rst_at == lat) begin
                rst = 1'b1;
                clr = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                lat = -1;
                return;
            end
            clr = (clr_at == lat);
            if (dvalid) break;
            busy_n += int'(busy);
            @(negedge clk);
            lat++;
        end
        clr = 1'b0;
        if (lat >= 200) check("valid_timeout", dvalid, 1'b1);
        hit_seen = hit;
    endtask

    task automatic consume();
        drdy = 1'b1;
        @(negedge clk);
        drdy = 1'b0;
        check("ready_after_consume", rdy, 1'b1);
    endtask

    initial begin
        logic [127:0] k3, k4, k6, held;
        logic [127:0] pool [4];
        int lat, bn;
        logic h;

        @(negedge clk);
        chk_en = 1'b1;
        rst    = 1'b0;
        @(negedge clk);
        check("reset_ready", rdy, 1'b1);
        check("reset_valid", dvalid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_hit", hit, 1'b0);
        check("reset_key", dkey, 128'd0);

        // Pin the model with hand-computed single-round schedules of a zero key.
        check("model80",  model_final(80, 1, '0),  128'h0000_0000_0000_C000_0000_0000_0000_8000);
        check("model128", model_final(128, 1, '0), 128'hCC00_0000_0000_0000_4000_0000_0000_0000);
        check("model64",  model_final(64, 1, '0),  128'hC000_0000_0000_8000);

        // Single-round instances: miss latency 2, then the same key hits in 1.
        kv_s = 1'b1;
        key_s = '0;
        @(negedge clk);
        kv_s = 1'b0;
        check("s1_busy80", b80, 1'b1);
        check("s1_valid80_early", v80, 1'b0);
        @(negedge clk);
        check("s1_valid80", v80, 1'b1);
        check("s1_key80", k80, 80'hC000_0000_0000_0000_8000);
        check("s1_hit80", h80, 1'b0);
        check("s1_valid128", v128, 1'b1);
        check("s1_key128", k128, 128'hCC00_0000_0000_0000_4000_0000_0000_0000);
        check("s1_key64", k64, 64'hC000_0000_0000_8000);
        drdy_s = 1'b1;
        @(negedge clk);
        drdy_s = 1'b0;
        check("s1_ready80", r80, 1'b1);
        kv_s = 1'b1;
        @(negedge clk);
        kv_s = 1'b0;
        check("s1_rehit80", h80, 1'b1);
        check("s1_revalid80", v80, 1'b1);
        check("s1_rekey80", k80, 80'hC000_0000_0000_0000_8000);
        check("s1_rehit128", h128, 1'b1);
        check("s1_rekey64", k64, 64'hC000_0000_0000_8000);
        drdy_s = 1'b1;
        @(negedge clk);
        drdy_s = 1'b0;

        // Full 31-round run, then a cache hit on the same key.
        k3 = {$urandom, $urandom, $urandom, $urandom};
        run_key(k3, -1, -1, lat, bn, h);
        check("t3_latency", lat, 32);
        check("t3_busy_cycles", bn, 31);
        check("t3_hit", h, 1'b0);
        check("t3_key", dkey, model_final(W, N, k3));
        consume();
        run_key(k3, -1, -1, lat, bn, h);
        check("t3_hit_latency", lat, 1);
        check("t3_hit_pulse", h, 1'b1);
        check("t3_hit_key", dkey, model_final(W, N, k3));
        consume();

        // Clear mid-run: result delivered but not cached.
        k4 = {$urandom, $urandom, $urandom, $urandom};
        run_key(k4, 5, -1, lat, bn, h);
        check("t4_latency", lat, 32);
        check("t4_key", dkey, model_final(W, N, k4));
        consume();
        run_key(k4, -1, -1, lat, bn, h);
        check("t4_remiss_latency", lat, 32);
        check("t4_remiss_busy", bn, 31);
        consume();
        // Clear on the accept cycle forces a miss even for the cached key.
        run_key(k4, 0, -1, lat, bn, h);
        check("t4_clear_accept_latency", lat, 32);

        // Backpressure: result held, inputs ignored.
        held = dkey;
        repeat (10) begin
            @(negedge clk);
            kv  = 1'($urandom);
            key = {$urandom, $urandom, $urandom, $urandom};
            check("t5_valid_held", dvalid, 1'b1);
            check("t5_ready_low", rdy, 1'b0);
            check("t5_key_held", dkey, held);
        end
        kv = 1'b0;
        consume();
        check("t5_valid_dropped", dvalid, 1'b0);
        run_key(k4, -1, -1, lat, bn, h);
        check("t5_hit_latency", lat, 1);
        check("t5_hit_pulse", h, 1'b1);
        consume();

        // Reset mid-run discards the result and the cache.
        k6 = {$urandom, $urandom, $urandom, $urandom};
        run_key(k6, -1, 10, lat, bn, h);
        check("t6_reset_taken", lat, -1);
        check("t6_ready", rdy, 1'b1);
        check("t6_busy", busy, 1'b0);
        check("t6_valid", dvalid, 1'b0);
        check("t6_hit", hit, 1'b0);
        check("t6_key", dkey, 128'd0);
        run_key(k4, -1, -1, lat, bn, h);
        check("t6_miss_latency", lat, 32);
        check("t6_miss_key", dkey, model_final(W, N, k4));
        consume();

        // Randomized traffic from a small key pool so hits, clears and stalls mix.
        pool[0] = k3;
        pool[1] = k4;
        pool[2] = {$urandom, $urandom, $urandom, $urandom};
        pool[3] = {$urandom, $urandom, $urandom, $urandom};
        repeat (3000) begin
            @(negedge clk);
            kv   = 1'($urandom_range(0, 1));
            key  = pool[$urandom_range(0, 3)];
            clr  = ($urandom_range(0, 19) == 0);
            drdy = ($urandom_range(0, 2) != 0);
            rst  = ($urandom_range(0, 499) == 0);
        end
        @(negedge clk);
        kv   = 1'b0;
        clr  = 1'b0;
        drdy = 1'b0;
        rst  = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
